// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multicycle RV32I control slice.
//   - opcode constants for the supported instruction classes
//   - controller state encoding (also exported on state_o for debug)
//   - alu_op codes
//   - op_class_t: one-hot instruction class produced by proc_opdec
package proc_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_TRAP = 3'd6
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic r;
    logic i;
    logic lw;
    logic sw;
    logic beq;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/proc_opdec.sv
// proc_opdec: combinational opcode -> instruction class one-hot.
// Shared with the datapath immediate generator.
//   opcode   in  7  instruction[6:0]
//   op_class out    one-hot {r, i, lw, sw, beq, illegal}
module proc_opdec
  import proc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    unique case (opcode)
      OP_R:    op_class.r       = 1'b1;
      OP_I:    op_class.i       = 1'b1;
      OP_LW:   op_class.lw      = 1'b1;
      OP_SW:   op_class.sw      = 1'b1;
      OP_BEQ:  op_class.beq     = 1'b1;
      default: op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multicycle control unit sequencing the shared datapath
// through BOOT/IF/ID/EX/MEM/WB (TRAP with CTRL_TRAP_EN).
// Build option: `define CTRL_TRAP_EN enables the TRAP state, the ready wait
// counter bounded by MEM_TIMEOUT, and the sticky trap output.
// Ports:
//   clk, rst (async, active-low)
//   opcode, zero, imem_ready, dmem_ready          controller inputs
//   imem_req, ir_write, alu_src, alu_op, mem_read,
//   mem_write, reg_write, mem_to_reg, pc_load,
//   pc_src                                         datapath controls
//   state_o                                        current state (debug)
//   trap                                           sticky fault flag
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_load,
  output logic       pc_src,
  output logic [2:0] state_o,
  output logic       trap
);

  state_t    state_q, state_d;
  op_class_t cls;
  logic      alu_src_dec;
  logic [1:0] alu_op_dec;

  proc_opdec u_opdec (
    .opcode   (opcode),
    .op_class (cls)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_BOOT;
    else      state_q <= state_d;
  end

`ifdef CTRL_TRAP_EN
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end

  // Any state change clears the count, so it is zero on every IF/MEM entry;
  // staying in IF/MEM only happens while ready is low.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)                       wait_cnt_d = '0;
    else if (state_q == ST_IF || state_q == ST_MEM) wait_cnt_d = wait_cnt_q + 8'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |8'(MEM_TIMEOUT);
`endif

  // ALU controls are decoded once and held from EX through MEM/WB.
  always_comb begin
    alu_src_dec = cls.i | cls.lw | cls.sw;
    if (cls.lw || cls.sw) alu_op_dec = ALU_ADD;
    else if (cls.beq)     alu_op_dec = ALU_SUB;
    else                  alu_op_dec = ALU_FUNCT;
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 1'b0;
    trap       = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        if (imem_ready) state_d = ST_ID;
`ifdef CTRL_TRAP_EN
        else if (wait_cnt_q == TIMEOUT) state_d = ST_TRAP;
`endif
      end
      ST_ID: begin
        if (!cls.illegal) begin
          state_d = ST_EX;
        end else begin
`ifdef CTRL_TRAP_EN
          state_d = ST_TRAP;
`else
          pc_load = 1'b1;
          state_d = ST_IF;
`endif
        end
      end
      ST_EX: begin
        alu_src = alu_src_dec;
        alu_op  = alu_op_dec;
        if (cls.beq) begin
          pc_load = 1'b1;
          pc_src  = zero;
          state_d = ST_IF;
        end else if (cls.lw || cls.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        alu_src   = alu_src_dec;
        alu_op    = alu_op_dec;
        mem_read  = cls.lw;
        mem_write = cls.sw;
        if (dmem_ready) begin
          if (cls.sw) begin
            pc_load = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
`ifdef CTRL_TRAP_EN
        else if (wait_cnt_q == TIMEOUT) state_d = ST_TRAP;
`endif
      end
      ST_WB: begin
        alu_src    = alu_src_dec;
        alu_op     = alu_op_dec;
        reg_write  = 1'b1;
        mem_to_reg = cls.lw;
        pc_load    = 1'b1;
        state_d    = ST_IF;
      end
      ST_TRAP: begin
`ifdef CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Multicycle control unit for the RV32I subset core: sequences the shared datapath (PC, instruction register, ALU, register file, data memory) through fetch/decode/execute/memory/writeback, one instruction at a time. Sits inside `top_proc` beside the datapath. It takes the latched opcode, the ALU `zero` flag and memory ready handshakes, and drives all datapath enables and selects.

## Interface
- `MEM_TIMEOUT`, 15: maximum wait cycles for `imem_ready`/`dmem_ready` before trap (used only with `CTRL_TRAP_EN`); 1..255.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction[6:0] from IR, stable from ID until return to IF.
- `zero`  in  1  ALU zero flag, valid in EX.
- `imem_ready`  in  1  instruction memory data valid this cycle.
- `dmem_ready`  in  1  data memory access complete this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_write`  out  1  latch instruction into IR.
- `alu_src`  out  1  0 = rs2, 1 = immediate.
- `alu_op`  out  2  00 add, 01 sub, 10 funct decode.
- `mem_read` / `mem_write`  out  1 each  data memory strobes.
- `reg_write`  out  1  register file write enable.
- `mem_to_reg`  out  1  writeback source: 0 ALU, 1 memory.
- `pc_load`  out  1  PC update enable, exactly one pulse per retired instruction.
- `pc_src`  out  1  0 = PC+4, 1 = branch target.
- `state_o`  out  3  current state, for debug.
- `trap`  out  1  sticky fault flag (constant 0 without `CTRL_TRAP_EN`).

## Operation
- States: BOOT=0, IF=1, ID=2, EX=3, MEM=4, WB=5, TRAP=6. Reset forces BOOT. All outputs are 0 in BOOT.
- Outputs are a combinational decode of the state register plus `opcode`, `zero` and ready inputs. They have no other input dependence.
- Supported classes: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ 1100011. Any other opcode is illegal.
- BOOT → IF unconditionally.
- IF: `imem_req`=1. `ir_write` = `imem_ready`. Go to ID on `imem_ready`, else stay.
- ID: no outputs. Legal opcode → EX. Illegal opcode → TRAP (with macro), or NOP without it: `pc_load`=1, `pc_src`=0, → IF.
- EX:
  - `alu_src` = 1 for I, LW and SW.
  - `alu_op` = 00 for LW/SW, 01 for BEQ, 10 for R/I.
  - BEQ: `pc_load`=1, `pc_src`=`zero`, → IF.
  - LW/SW → MEM. R/I → WB.
- MEM: `alu_src`/`alu_op` are held. `mem_read`=LW, `mem_write`=SW, both held until `dmem_ready`.
  - On `dmem_ready`: SW asserts `pc_load`=1 (`pc_src`=0) and goes → IF; LW goes → WB.
- WB: `reg_write`=1, `mem_to_reg`=LW, `pc_load`=1, `pc_src`=0. `alu_src`/`alu_op` are held. → IF.
- TRAP: all outputs 0 except `trap`=1. Exits only by reset.

## Timing
- Minimum cycles per instruction, counting zero-wait memory from IF entry to the next IF entry: R/I 4, LW 5, SW 4, BEQ 3, illegal-NOP 2.
- The first IF begins 1 cycle after `rst` deasserts (BOOT cycle).
- Each cycle of ready low in IF/MEM adds exactly 1 cycle. Strobes stay asserted and constant while waiting.
- Reset mid-instruction: all outputs drop to 0 immediately, asynchronously. There is no partial `pc_load` or `reg_write`.
- `ir_write` and `pc_load` never assert in the same cycle.

## Configuration
- `CTRL_TRAP_EN` defined:
  - TRAP state and `trap` output are active.
  - Illegal opcode → TRAP.
  - The wait counter is compiled in. It clears on entry to IF/MEM and increments each cycle ready is low.
  - When the counter equals `MEM_TIMEOUT` with ready still low → TRAP next edge. A ready arriving in that same cycle wins.
- Undefined: no counter, ready waits are unbounded, illegal opcode executes as NOP, and `trap` is tied to 0.

## Structure
- Shared package `proc_pkg`: opcode constants, state encoding, `alu_op` codes.
- Sub-module `proc_opdec`: combinational opcode → class one-hot (r, i, lw, sw, beq, illegal). It is reusable by the datapath immediate generator.

## Test plan
- Reset release, ready held 1, opcode 0110011 → `state_o` sequence 0,1,2,3,5,1. `reg_write` high only in state 5. One `pc_load` pulse.
- LW with `dmem_ready` low for 3 MEM cycles → `mem_read` high for 4 cycles, then WB with `mem_to_reg`=1. 8 cycles from IF entry to the next IF entry.
- BEQ with `zero`=1 → `pc_load`=1, `pc_src`=1 in EX. With `zero`=0 → `pc_src`=0. Neither case has any `reg_write`.
- SW → `mem_write`=1, `pc_load` coinciding with `dmem_ready`, `reg_write` never asserted.
- Opcode 1111111 → with macro: `trap`=1, `state_o`=6 held. Without macro: ID pulses `pc_load`, returns to IF.
- With macro and MEM_TIMEOUT=15, `imem_ready` held 0 → TRAP after 16 IF cycles. Assert `rst`=0 mid-EX → all outputs 0 in the same cycle.
